seq_arith_unit: RTL

- Parametrised, clocked successor to the team's task-based add/repeated-add product block.
- Performs unsigned add, subtract and shift-add multiply on N-bit operands; result width is 2N.
- Uses a start/busy/done handshake and is usable in synthesised datapaths.
- Sits between an operand-issuing controller and a result register bank; one operation in flight at a time.

---
 rtl/seq_arith_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: clocked unsigned add / subtract / shift-add multiply.
// N-bit operands, 2N-bit registered result, start/busy/done handshake.
// One operation in flight; operands are captured when the request is accepted.
// Optional build macro SEQ_ARITH_EARLY_TERM_EN: the multiply finishes as soon as
// no set bits of the captured y remain to be processed.
module seq_arith_unit #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result,
  output logic           flag
);

  localparam int CW = $clog2(N) + 1;
  localparam int RW = 2 * N;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_e;
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   y_q, y_d;
  logic [RW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]  result_q, result_d;
  logic           flag_q, flag_d;

  logic [RW-1:0]  x_ext, y_ext;
  logic [RW-1:0]  add_res, sub_res;
  logic [N-1:0]   bit_mask;
  logic           y_bit;
  logic [RW-1:0]  acc_sum;
  logic           mul_last;

  // Datapath: widened operands, add/sub results and one multiply iteration.
  always_comb begin
    x_ext    = {{N{1'b0}}, x_q};
    y_ext    = {{N{1'b0}}, y_q};
    add_res  = x_ext + y_ext;
    sub_res  = x_ext - y_ext;
    bit_mask = N'(1) << cnt_q;
    y_bit    = |(y_q & bit_mask);
    acc_sum  = acc_q + (y_bit ? (x_ext << cnt_q) : '0);
`ifdef SEQ_ARITH_EARLY_TERM_EN
    // Done once the bit being processed is the last one, or nothing set remains above it.
    mul_last = (cnt_q == CW'(N - 1)) || (((y_q >> cnt_q) >> 1) == '0);
`else
    mul_last = (cnt_q == CW'(N - 1));
`endif
  end

  // Next-state and register-update logic for the control FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_d   = flag_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          x_d     = x;
          y_d     = y;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (op_e'(op) == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (op_q)
          OP_ADD: begin
            result_d = add_res;
            flag_d   = add_res[N];
          end
          OP_SUB: begin
            result_d = sub_res;
            flag_d   = (x_q < y_q);
          end
          default: begin
            // Illegal opcode (multiply never reaches EXEC).
            result_d = '0;
            flag_d   = 1'b1;
          end
        endcase
        state_d = S_DONE;
      end
      S_MUL: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
        if (mul_last) begin
          result_d = acc_sum;
          flag_d   = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // Requests are ignored here; the earliest re-accept is from IDLE.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, datapath included, is reset so an aborted operation leaves no stale state.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign busy   = (state_q == S_EXEC) || (state_q == S_MUL);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign flag   = flag_q;

endmodule
